cpu_datapath: RTL and testbench

- 32-bit single-bus CPU datapath: sixteen general registers R0–R15, plus PC, IR, MAR, MDR, Y, HI, LO and a 64-bit Z register.
- All registers share one 32-bit internal bus.
- The ALU takes Y as operand A and the bus as operand B; results go into Z.
- Sequenced cycle by cycle by an external control unit or bench that asserts the in/out strobes.

---
 rtl/cpu_datapath.sv | 253 +++++++++++++++++++++++++
 tb/tb_cpu_datapath.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_datapath.sv
// ---------------------------------------------------------------------------
// cpu_datapath
// 32-bit single-bus CPU datapath. Sixteen general registers plus PC, IR, MAR,
// MDR, Y, HI, LO and a 64-bit Z register all share one internal bus. The ALU
// takes Y as operand A and the bus as operand B; its 64-bit {hi, lo} result is
// captured into Z. An external control unit sequences the datapath by driving
// the in/out strobes one cycle at a time.
// ---------------------------------------------------------------------------
module cpu_datapath #(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               clear,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   RegisterImmediate,
    input  logic               Read,
    input  logic [WIDTH-1:0]   Mdatain,
    input  logic [3:0]         ALUop,
    input  logic               ALU_MUL,
    input  logic               ALU_DIV,
    input  logic [15:0]        Rin,
    input  logic [15:0]        Rout,
    input  logic               MARin,
    input  logic               PCin,
    input  logic               IRin,
    input  logic               Yin,
    input  logic               MDRin,
    input  logic               HIin,
    input  logic               LOin,
    input  logic               Zhighin,
    input  logic               Zlowin,
    input  logic               PCout,
    input  logic               IRout,
    input  logic               Yout,
    input  logic               MDRout,
    input  logic               HIout,
    input  logic               LOout,
    input  logic               Zhighout,
    input  logic               Zlowout,
    output logic [WIDTH-1:0]   MARout
);

    // ALU operation encodings for the ALUop path
    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_NOT  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_NEG  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_SHRA = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_ROR  = 4'd9;
    localparam logic [3:0] OP_ROL  = 4'd10;

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    // Rotate right by s bits (s taken modulo 32)
    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] v,
                                              input logic [4:0]       s);
        logic [5:0] back;
        back = 6'd32 - {1'b0, s};
        return (v >> s) | (v << back);
    endfunction

    // Rotate left by s bits (s taken modulo 32)
    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v,
                                              input logic [4:0]       s);
        logic [5:0] back;
        back = 6'd32 - {1'b0, s};
        return (v << s) | (v >> back);
    endfunction

    // Architectural state
    logic [WIDTH-1:0]   gpr_r [16];
    logic [WIDTH-1:0]   pc_r;
    logic [WIDTH-1:0]   ir_r;
    logic [WIDTH-1:0]   mar_r;
    logic [WIDTH-1:0]   mdr_r;
    logic [WIDTH-1:0]   y_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic [2*WIDTH-1:0] z_r;

    // Combinational datapath signals
    logic [WIDTH-1:0]          bus_s;
    logic                      rsel_hit_s;
    logic [3:0]                rsel_idx_s;
    logic [4:0]                shamt_s;
    logic [WIDTH-1:0]          op_lo_s;
    logic signed [2*WIDTH-1:0] mul_full_s;
    logic [WIDTH-1:0]          div_den_s;
    logic signed [WIDTH-1:0]   quot_s;
    logic signed [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]          alu_hi_s;
    logic [WIDTH-1:0]          alu_lo_s;

    // The in-port and immediate inputs are reserved; they are gathered here
    // so that they are visibly intentional rather than forgotten.
    logic reserved_unused_s;
    assign reserved_unused_s = ^{A, RegisterImmediate};

    // Find the lowest-numbered general register requesting the bus
    always_comb begin
        rsel_hit_s = 1'b0;
        rsel_idx_s = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            rsel_hit_s = rsel_hit_s | Rout[i];
            rsel_idx_s = Rout[i] ? i[3:0] : rsel_idx_s;
        end
    end

    // Bus multiplexer: fixed priority, general registers first, zero when idle
    always_comb begin
        bus_s = '0;
        if (rsel_hit_s) begin
            bus_s = gpr_r[rsel_idx_s];
        end else if (HIout) begin
            bus_s = hi_r;
        end else if (LOout) begin
            bus_s = lo_r;
        end else if (Zhighout) begin
            bus_s = z_r[2*WIDTH-1:WIDTH];
        end else if (Zlowout) begin
            bus_s = z_r[WIDTH-1:0];
        end else if (PCout) begin
            bus_s = pc_r;
        end else if (MDRout) begin
            bus_s = mdr_r;
        end else if (IRout) begin
            bus_s = ir_r;
        end else if (Yout) begin
            bus_s = y_r;
        end else begin
            bus_s = '0;
        end
    end

    // Single-word ALU operations (A = Y, B = bus)
    always_comb begin
        shamt_s = bus_s[4:0];
        op_lo_s = '0;
        case (ALUop)
            OP_AND:  op_lo_s = y_r & bus_s;
            OP_OR:   op_lo_s = y_r | bus_s;
            OP_NOT:  op_lo_s = ~bus_s;
            OP_ADD:  op_lo_s = y_r + bus_s;
            OP_SUB:  op_lo_s = y_r - bus_s;
            OP_NEG:  op_lo_s = {WIDTH{1'b0}} - bus_s;
            OP_SHR:  op_lo_s = y_r >> shamt_s;
            OP_SHRA: op_lo_s = $unsigned($signed(y_r) >>> shamt_s);
            OP_SHL:  op_lo_s = y_r << shamt_s;
            OP_ROR:  op_lo_s = rotr(y_r, shamt_s);
            OP_ROL:  op_lo_s = rotl(y_r, shamt_s);
            default: op_lo_s = '0;
        endcase
    end

    // Signed multiply and divide. The divisor is replaced by one for a zero
    // divisor (result overridden below) and for MIN_NEG / -1, where dividing
    // by one gives the same two's-complement wrapped quotient and zero
    // remainder without an arithmetic overflow.
    always_comb begin
        mul_full_s = $signed({{WIDTH{y_r[WIDTH-1]}}, y_r})
                   * $signed({{WIDTH{bus_s[WIDTH-1]}}, bus_s});
        if ((bus_s == '0) || ((y_r == MIN_NEG) && (bus_s == ALL_ONES))) begin
            div_den_s = ONE_W;
        end else begin
            div_den_s = bus_s;
        end
        quot_s = $signed(y_r) / $signed(div_den_s);
        rem_s  = $signed(y_r) % $signed(div_den_s);
    end

    // ALU result path selection: multiply, then divide, then ALUop
    always_comb begin
        alu_hi_s = '0;
        alu_lo_s = '0;
        if (ALU_MUL) begin
            alu_hi_s = mul_full_s[2*WIDTH-1:WIDTH];
            alu_lo_s = mul_full_s[WIDTH-1:0];
        end else if (ALU_DIV) begin
            if (bus_s == '0) begin
                alu_hi_s = y_r;
                alu_lo_s = ALL_ONES;
            end else begin
                alu_hi_s = $unsigned(rem_s);
                alu_lo_s = $unsigned(quot_s);
            end
        end else begin
            alu_hi_s = '0;
            alu_lo_s = op_lo_s;
        end
    end

    // General register file: each register loads the bus when enabled
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < 16; i++) begin
                gpr_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (Rin[i]) begin
                    gpr_r[i] <= bus_s;
                end
            end
        end
    end

    // Special-purpose registers that load straight from the bus
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            pc_r  <= '0;
            ir_r  <= '0;
            mar_r <= '0;
            y_r   <= '0;
            hi_r  <= '0;
            lo_r  <= '0;
        end else begin
            if (PCin)  pc_r  <= bus_s;
            if (IRin)  ir_r  <= bus_s;
            if (MARin) mar_r <= bus_s;
            if (Yin)   y_r   <= bus_s;
            if (HIin)  hi_r  <= bus_s;
            if (LOin)  lo_r  <= bus_s;
        end
    end

    // Memory data register: loads memory read data or the bus
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            mdr_r <= '0;
        end else if (MDRin) begin
            mdr_r <= Read ? Mdatain : bus_s;
        end
    end

    // Z register: high and low halves capture the ALU result independently
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            z_r <= '0;
        end else begin
            if (Zhighin) z_r[2*WIDTH-1:WIDTH] <= alu_hi_s;
            if (Zlowin)  z_r[WIDTH-1:0]       <= alu_lo_s;
        end
    end

    assign MARout = mar_r;

endmodule

// File: tb/tb_cpu_datapath.sv
// ---------------------------------------------------------------------------
// tb_cpu_datapath
// Directed, self-checking bench for cpu_datapath. The only visible output is
// MARout, so every register is observed by driving it onto the bus and
// loading it into MAR.
// ---------------------------------------------------------------------------
module tb_cpu_datapath;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] A;
    logic [31:0] RegisterImmediate;
    logic        Read;
    logic [31:0] Mdatain;
    logic [3:0]  ALUop;
    logic        ALU_MUL;
    logic        ALU_DIV;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic        MARin, PCin, IRin, Yin, MDRin, HIin, LOin, Zhighin, Zlowin;
    logic        PCout, IRout, Yout, MDRout, HIout, LOout, Zhighout, Zlowout;
    logic [31:0] MARout;

    int errors = 0;
    int checks = 0;

    cpu_datapath #(.WIDTH(32)) dut (
        .clock(clock), .clear(clear), .A(A),
        .RegisterImmediate(RegisterImmediate), .Read(Read),
        .Mdatain(Mdatain), .ALUop(ALUop), .ALU_MUL(ALU_MUL),
        .ALU_DIV(ALU_DIV), .Rin(Rin), .Rout(Rout), .MARin(MARin),
        .PCin(PCin), .IRin(IRin), .Yin(Yin), .MDRin(MDRin), .HIin(HIin),
        .LOin(LOin), .Zhighin(Zhighin), .Zlowin(Zlowin), .PCout(PCout),
        .IRout(IRout), .Yout(Yout), .MDRout(MDRout), .HIout(HIout),
        .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .MARout(MARout)
    );

    always #5 clock = ~clock;

    // Source codes for peek: 0-15 R0-R15, then the special registers
    localparam int S_HI = 16, S_LO = 17, S_ZH = 18, S_ZL = 19;
    localparam int S_PC = 20, S_MDR = 21, S_IR = 22, S_Y = 23;

    task automatic zero_ctl();
        A = 32'd0; RegisterImmediate = 32'd0; Read = 1'b0; Mdatain = 32'd0;
        ALUop = 4'd0; ALU_MUL = 1'b0; ALU_DIV = 1'b0;
        Rin = 16'd0; Rout = 16'd0;
        MARin = 1'b0; PCin = 1'b0; IRin = 1'b0; Yin = 1'b0; MDRin = 1'b0;
        HIin = 1'b0; LOin = 1'b0; Zhighin = 1'b0; Zlowin = 1'b0;
        PCout = 1'b0; IRout = 1'b0; Yout = 1'b0; MDRout = 1'b0;
        HIout = 1'b0; LOout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        zero_ctl();
    endtask

    task automatic chk(input string tag, input logic [31:0] exp);
        checks++;
        assert (MARout === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, MARout, exp);
        end
    endtask

    task automatic drive_out(input int src);
        if (src < 16) begin
            Rout[src] = 1'b1;
        end else begin
            case (src)
                S_HI:    HIout    = 1'b1;
                S_LO:    LOout    = 1'b1;
                S_ZH:    Zhighout = 1'b1;
                S_ZL:    Zlowout  = 1'b1;
                S_PC:    PCout    = 1'b1;
                S_MDR:   MDRout   = 1'b1;
                S_IR:    IRout    = 1'b1;
                default: Yout     = 1'b1;
            endcase
        end
    endtask

    task automatic peek(input string tag, input int src, input logic [31:0] exp);
        drive_out(src);
        MARin = 1'b1;
        tick();
        chk(tag, exp);
    endtask

    task automatic set_mdr(input logic [31:0] v);
        Read = 1'b1; MDRin = 1'b1; Mdatain = v;
        tick();
    endtask

    task automatic load_y(input logic [31:0] v);
        set_mdr(v);
        MDRout = 1'b1; Yin = 1'b1;
        tick();
    endtask

    task automatic load_r(input int idx, input logic [31:0] v);
        set_mdr(v);
        MDRout = 1'b1; Rin[idx] = 1'b1;
        tick();
    endtask

    task automatic alu(input logic [3:0] op, input logic mul, input logic dv,
                       input logic [31:0] b);
        set_mdr(b);
        MDRout = 1'b1; ALUop = op; ALU_MUL = mul; ALU_DIV = dv;
        Zhighin = 1'b1; Zlowin = 1'b1;
        tick();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        zero_ctl();
        clear = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_initial_mar", 32'h0);
        clear = 1'b1;

        // Fill every register with non-zero data before a mid-run reset
        set_mdr(32'hDEADBEEF);
        MDRout = 1'b1; Rin = 16'hFFFF; PCin = 1'b1; IRin = 1'b1; Yin = 1'b1;
        HIin = 1'b1; LOin = 1'b1; MARin = 1'b1;
        tick();
        chk("preload_mar", 32'hDEADBEEF);
        MDRout = 1'b1; ALU_MUL = 1'b1; Zhighin = 1'b1; Zlowin = 1'b1;
        tick();

        // Asynchronous reset in mid-cycle with strobes active
        Rin = 16'hFFFF; MDRout = 1'b1; MARin = 1'b1; Read = 1'b1;
        MDRin = 1'b1; Mdatain = 32'hFFFFFFFF; PCin = 1'b1; Zlowin = 1'b1;
        #2;
        clear = 1'b0;
        #1;
        chk("reset_async_mar", 32'h0);
        @(posedge clock);
        #1;
        chk("reset_held_mar", 32'h0);
        clear = 1'b1;
        zero_ctl();
        for (int s = 0; s < 24; s++) begin
            peek($sformatf("reset_src%0d", s), s, 32'h0);
        end

        // Load and add
        load_r(5, 32'h34);
        load_r(6, 32'h45);
        peek("r5_load", 5, 32'h34);
        Rout[5] = 1'b1; Yin = 1'b1;
        tick();
        Rout[6] = 1'b1; ALUop = 4'd3; Zlowin = 1'b1;
        tick();
        Zlowout = 1'b1; Rin[2] = 1'b1;
        tick();
        peek("add_r2", 2, 32'h79);

        // Instruction fetch
        peek("fetch_pc_to_mar", S_PC, 32'h0);
        set_mdr(32'h12345678);
        MDRout = 1'b1; IRin = 1'b1;
        tick();
        peek("fetch_ir", S_IR, 32'h12345678);

        // Multiply and divide
        load_y(32'hFFFFFFFE);
        alu(4'd0, 1'b1, 1'b0, 32'd3);
        peek("mul_hi", S_ZH, 32'hFFFFFFFF);
        peek("mul_lo", S_ZL, 32'hFFFFFFFA);

        // Z low drives old value while loading; Z high must hold
        load_y(32'd5);
        Zlowout = 1'b1; MARin = 1'b1; ALUop = 4'd3; Zlowin = 1'b1;
        tick();
        chk("z_old_on_bus", 32'hFFFFFFFA);
        peek("z_lo_updated", S_ZL, 32'hFFFFFFFF);
        peek("z_hi_held", S_ZH, 32'hFFFFFFFF);

        load_y(32'hFFFFFFF9);
        alu(4'd0, 1'b0, 1'b1, 32'd2);
        peek("div_quot", S_ZL, 32'hFFFFFFFD);
        peek("div_rem", S_ZH, 32'hFFFFFFFF);
        load_y(32'd5);
        alu(4'd0, 1'b0, 1'b1, 32'd0);
        peek("div0_lo", S_ZL, 32'hFFFFFFFF);
        peek("div0_hi", S_ZH, 32'h5);
        alu(4'd3, 1'b1, 1'b1, 32'd4);
        peek("mul_over_div", S_ZL, 32'd20);

        // Logic, shifts and rotates with Y=0x80000001, bus=1
        load_y(32'h80000001);
        alu(4'd7, 1'b0, 1'b0, 32'd1);
        peek("shra", S_ZL, 32'hC0000000);
        peek("aluop_hi_zero", S_ZH, 32'h0);
        alu(4'd6, 1'b0, 1'b0, 32'd1);
        peek("shr", S_ZL, 32'h40000000);
        alu(4'd9, 1'b0, 1'b0, 32'd1);
        peek("ror", S_ZL, 32'hC0000000);
        alu(4'd10, 1'b0, 1'b0, 32'd1);
        peek("rol", S_ZL, 32'h00000003);
        alu(4'd8, 1'b0, 1'b0, 32'd1);
        peek("shl", S_ZL, 32'h00000002);
        alu(4'd0, 1'b0, 1'b0, 32'd1);
        peek("and", S_ZL, 32'h00000001);
        alu(4'd1, 1'b0, 1'b0, 32'd6);
        peek("or", S_ZL, 32'h80000007);
        alu(4'd2, 1'b0, 1'b0, 32'd1);
        peek("not_b", S_ZL, 32'hFFFFFFFE);
        alu(4'd5, 1'b0, 1'b0, 32'd1);
        peek("neg", S_ZL, 32'hFFFFFFFF);
        alu(4'd12, 1'b0, 1'b0, 32'd1);
        peek("op12_zero", S_ZL, 32'h0);
        load_y(32'd0);
        alu(4'd4, 1'b0, 1'b0, 32'd1);
        peek("sub", S_ZL, 32'hFFFFFFFF);

        // Bus priority
        load_r(3, 32'h33);
        load_r(7, 32'h77);
        Rout[3] = 1'b1; Rout[7] = 1'b1; Rin[1] = 1'b1;
        tick();
        peek("prio_r3_over_r7", 1, 32'h33);
        Rin[1] = 1'b1;
        tick();
        peek("idle_bus_zero", 1, 32'h0);
        set_mdr(32'hAAAA5555);
        MDRout = 1'b1; HIin = 1'b1;
        tick();
        set_mdr(32'h1);
        MDRout = 1'b1; PCin = 1'b1;
        tick();
        HIout = 1'b1; PCout = 1'b1; Rin[4] = 1'b1;
        tick();
        peek("prio_hi_over_pc", 4, 32'hAAAA5555);
        load_r(15, 32'hF0F0);
        Rout[15] = 1'b1; HIout = 1'b1; Rin[4] = 1'b1;
        tick();
        peek("prio_r15_over_hi", 4, 32'hF0F0);
        load_r(0, 32'h5A);
        Rout[0] = 1'b1; Rout[3] = 1'b1; MARin = 1'b1;
        tick();
        chk("prio_r0_over_r3", 32'h5A);

        // MDR loads the bus when Read is low
        Rout[3] = 1'b1; MDRin = 1'b1; Read = 1'b0; Mdatain = 32'hDEADDEAD;
        tick();
        peek("mdr_from_bus", S_MDR, 32'h33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
